mouse_packet_decoder: RTL and testbench
=======================================

# mouse_packet_decoder

Assembles PS/2 mouse bytes from the PS/2 receiver into complete movement packets and maintains an absolute, screen-clamped cursor position plus button state. Sits directly upstream of the board/button decoder: its `x_o`, `y_o`, `btn_o` and `valid_o` drive that stage's `x_i`, `y_i`, `btn_i` and `valid_i`. One update pulse is produced per accepted packet.

## Interface
- `H_RES`, 640: horizontal screen size in pixels; x range 0..H_RES-1.
- `V_RES`, 480: vertical screen size in pixels; y range 0..V_RES-1.
- `TIMEOUT`, 200000: maximum clk cycles between bytes of one packet (2 ms at 100 MHz).
- `clk`  in  1  system clock; single clock domain.
- `rst_n`  in  1  reset; synchronous, active-low.
- `rx_data`  in  8  byte from the PS/2 receiver.
- `rx_valid`  in  1  one-cycle strobe; `rx_data` is valid when high.
- `x_o`  out  12  cursor x, 0..H_RES-1.
- `y_o`  out  12  cursor y, 0..V_RES-1 (0 = top).
- `btn_o`  out  8  [0] left, [1] right, [2] middle, [3] 0, [7:4] wheel delta (see Configuration).
- `valid_o`  out  1  one-cycle pulse: new packet applied to outputs.
- `sync_err_o`  out  1  one-cycle pulse: byte dropped or packet aborted.

## Operation
- Reset (rst_n=0 at a clk edge): state S_B0; x_o=H_RES/2 (320), y_o=V_RES/2 (240), btn_o=0, valid_o=0, sync_err_o=0, timeout counter=0.
- States: S_B0 -> S_B1 -> S_B2 -> (S_B3 when wheel enabled) -> S_B0.
- S_B0: on rx_valid, accept byte only if bit3=1 (sync bit); latch it, go to S_B1. If bit3=0: drop, pulse sync_err_o, stay.
- S_B1: on rx_valid latch dx byte; S_B2: on rx_valid latch dy byte, then packet complete (or go to S_B3).
- Byte0 fields: [0] L, [1] R, [2] M, [4] X sign, [5] Y sign, [6] X overflow, [7] Y overflow.
- Delta: 9-bit two's complement {sign, byte}, sign-extended to 13 bits. Overflow bit set -> that axis delta = 0.
- Update: x_new = x + dx; y_new = y - dy (mouse up = screen up). 13-bit signed arithmetic; clamp to [0, H_RES-1] / [0, V_RES-1].
- btn_o[2:0] takes byte0[2:0] on every completed packet; btn_o[3]=0 always.
- Timeout: counter clears on every accepted byte; increments while in S_B1..S_B3; reaching TIMEOUT -> abort to S_B0, pulse sync_err_o, no output update, partial bytes discarded.
- Position and buttons change only on packet completion; valid_o pulses even if position/buttons unchanged.

## Timing
- Latency: final byte's rx_valid at edge N -> x_o/y_o/btn_o updated and valid_o=1 for exactly the cycle after edge N+1 (one register stage after latch).
- Back-to-back rx_valid on consecutive cycles accepted at full rate; no backpressure.
- rx_valid during the valid_o cycle is accepted as next packet's byte0.
- Timeout and rx_valid in same cycle: byte wins, counter clears.
- Reset mid-packet discards partial packet; outputs return to reset values next cycle.

## Configuration
- `MOUSE_WHEEL_EN` defined: 4-byte IntelliMouse packets; S_B3 latches byte3; btn_o[7:4] = byte3[3:0] (signed wheel delta) for that packet, valid_o after byte3.
- Undefined: 3-byte packets, S_B3 absent, btn_o[7:4] tied 0.

## Structure
- Package `mouse_pkg`: state encoding, byte0 bit indices (sync, signs, overflows, buttons), BTN_* positions in btn_o, coordinate width 12, arithmetic width 13.
- Sub-module `mouse_axis_accum` (instanced twice, x and y): params MAX, INVERT; inputs 9-bit delta, overflow, apply strobe; holds and clamps one coordinate.

## Test plan
- Reset, then packet 0x09,0x0A,0x05 -> valid_o once; x_o=330, y_o=235, btn_o=0x01.
- From reset, byte0=0x18, dx=0xF6 (-10) -> x_o=310; repeated -100 steps saturate x_o at 0, never wrap.
- Byte0=0x02 (bit3=0) -> sync_err_o pulse, dropped; following 0x08,0x00,0x00 -> valid_o, position unchanged.
- Byte0 then dx, then idle TIMEOUT cycles -> sync_err_o, no valid_o; next full packet decodes correctly.
- Byte0=0x48 (X overflow), dx=0x7F -> x_o unchanged, y applied normally.
- With `MOUSE_WHEEL_EN`: 0x08,0x00,0x00,0x0F -> valid_o after 4th byte, btn_o[7:4]=0xF.

Source files
------------

// File: rtl/mouse_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | mouse_pkg                                                                  |
// | Shared types and constants for the PS/2 mouse packet decoder.              |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
package mouse_pkg;

   typedef enum logic [1:0] {
      S_B0 = 2'd0,
      S_B1 = 2'd1,
      S_B2 = 2'd2,
      S_B3 = 2'd3
   } state_t;

   localparam int COORD_W = 12;
   localparam int ARITH_W = 13;

   // Field positions within the first packet byte
   localparam int B0_BTN_L  = 0;
   localparam int B0_BTN_R  = 1;
   localparam int B0_BTN_M  = 2;
   localparam int B0_SYNC   = 3;
   localparam int B0_X_SIGN = 4;
   localparam int B0_Y_SIGN = 5;
   localparam int B0_X_OVF  = 6;
   localparam int B0_Y_OVF  = 7;

   // Field positions within btn_o
   localparam int BTN_L         = 0;
   localparam int BTN_R         = 1;
   localparam int BTN_M         = 2;
   localparam int BTN_RSVD      = 3;
   localparam int BTN_WHEEL_LSB = 4;
   localparam int BTN_WHEEL_MSB = 7;

   // 9-bit {sign, byte} movement widened for clamped arithmetic; overflow forces zero
   function automatic logic signed [ARITH_W-1:0] sext_delta(input logic [8:0] d,
                                                           input logic       ovf);
      if (ovf) begin
         return '0;
      end
      return {{(ARITH_W-9){d[8]}}, d};
   endfunction

endpackage
`default_nettype wire

// File: rtl/mouse_axis_accum.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | mouse_axis_accum                                                           |
// | Holds one cursor coordinate, applies a signed delta and clamps to 0..MAX. |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
import mouse_pkg::*;

module mouse_axis_accum #(
   parameter int MAX    = 639,
   parameter bit INVERT = 1'b0
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic [8:0]         delta,
   input  logic               overflow,
   input  logic               apply,
   output logic [COORD_W-1:0] coord
);

   localparam logic [COORD_W-1:0]        c_home = COORD_W'((MAX + 1) / 2);
   localparam logic signed [ARITH_W-1:0] c_max  = ARITH_W'(MAX);

   logic [COORD_W-1:0]        r_coord;
   logic [COORD_W-1:0]        w_next;
   logic signed [ARITH_W-1:0] w_step;
   logic signed [ARITH_W-1:0] w_cur;
   logic signed [ARITH_W-1:0] w_sum;

   always_comb begin
      w_step = sext_delta(delta, overflow);
      w_cur  = $signed({1'b0, r_coord});
      w_sum  = INVERT ? (w_cur - w_step) : (w_cur + w_step);
      if (w_sum < 0) begin
         w_next = '0;
      end else if (w_sum > c_max) begin
         w_next = COORD_W'(c_max);
      end else begin
         w_next = w_sum[COORD_W-1:0];
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_coord <= c_home;
      end else if (apply) begin
         r_coord <= w_next;
      end
   end

   assign coord = r_coord;

endmodule
`default_nettype wire

// File: rtl/mouse_packet_decoder.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | mouse_packet_decoder                                                       |
// | Assembles PS/2 mouse bytes into packets; tracks clamped cursor + buttons.  |
// | Optional 4-byte wheel packets: define MOUSE_WHEEL_EN.                      |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
import mouse_pkg::*;

module mouse_packet_decoder #(
   parameter int H_RES   = 640,
   parameter int V_RES   = 480,
   parameter int TIMEOUT = 200000
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [7:0]  rx_data,
   input  logic        rx_valid,
   output logic [11:0] x_o,
   output logic [11:0] y_o,
   output logic [7:0]  btn_o,
   output logic        valid_o,
   output logic        sync_err_o
);

   localparam int                  c_tmr_w    = $clog2(TIMEOUT + 1);
   localparam logic [c_tmr_w-1:0]  c_tmr_last = c_tmr_w'(TIMEOUT - 1);

   state_t              r_state;
   state_t              w_state_next;
   logic [c_tmr_w-1:0]  r_timer;

   logic                w_lat_b0;
   logic                w_lat_dx;
   logic                w_lat_dy;
   logic                w_complete;
   logic                w_drop;
   logic                w_abort;
   logic                w_tmr_clr;
   logic                w_tmr_inc;

   logic [2:0]          r_b0_btn;
   logic                r_x_sign;
   logic                r_y_sign;
   logic                r_x_ovf;
   logic                r_y_ovf;
   logic [7:0]          r_dx;
   logic [7:0]          r_dy;
   logic                r_apply;
   logic                r_valid;
   logic                r_sync_err;
   logic [7:0]          r_btn;
   logic [7:0]          w_btn_next;
   logic [3:0]          w_wheel;

`ifdef MOUSE_WHEEL_EN
   logic                w_lat_wh;
   logic [3:0]          r_wheel;
`endif

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state <= S_B0;
      end else begin
         r_state <= w_state_next;
      end
   end

   always_comb begin
      w_state_next = r_state;
      w_lat_b0     = 1'b0;
      w_lat_dx     = 1'b0;
      w_lat_dy     = 1'b0;
      w_complete   = 1'b0;
      w_drop       = 1'b0;
      w_abort      = 1'b0;
      w_tmr_clr    = 1'b0;
      w_tmr_inc    = 1'b0;
`ifdef MOUSE_WHEEL_EN
      w_lat_wh     = 1'b0;
`endif
      case (r_state)
         S_B0: begin
            w_tmr_clr = 1'b1;
            if (rx_valid) begin
               if (rx_data[B0_SYNC]) begin
                  w_lat_b0     = 1'b1;
                  w_state_next = S_B1;
               end else begin
                  w_drop = 1'b1;
               end
            end
         end
         S_B1, S_B2, S_B3: begin
            // An arriving byte takes priority over an expiring timer
            if (rx_valid) begin
               w_tmr_clr = 1'b1;
               case (r_state)
                  S_B1: begin
                     w_lat_dx     = 1'b1;
                     w_state_next = S_B2;
                  end
                  S_B2: begin
                     w_lat_dy = 1'b1;
`ifdef MOUSE_WHEEL_EN
                     w_state_next = S_B3;
`else
                     w_complete   = 1'b1;
                     w_state_next = S_B0;
`endif
                  end
                  default: begin
`ifdef MOUSE_WHEEL_EN
                     w_lat_wh   = 1'b1;
                     w_complete = 1'b1;
`endif
                     w_state_next = S_B0;
                  end
               endcase
            end else if (r_timer == c_tmr_last) begin
               w_abort      = 1'b1;
               w_tmr_clr    = 1'b1;
               w_state_next = S_B0;
            end else begin
               w_tmr_inc = 1'b1;
            end
         end
         default: begin
            w_state_next = S_B0;
         end
      endcase
   end

`ifdef MOUSE_WHEEL_EN
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_wheel <= '0;
      end else if (w_lat_wh) begin
         r_wheel <= rx_data[3:0];
      end
   end

   assign w_wheel = r_wheel;
`else
   assign w_wheel = 4'h0;
`endif

   always_comb begin
      w_btn_next                              = '0;
      w_btn_next[BTN_L]                       = r_b0_btn[B0_BTN_L];
      w_btn_next[BTN_R]                       = r_b0_btn[B0_BTN_R];
      w_btn_next[BTN_M]                       = r_b0_btn[B0_BTN_M];
      w_btn_next[BTN_RSVD]                    = 1'b0;
      w_btn_next[BTN_WHEEL_MSB:BTN_WHEEL_LSB] = w_wheel;
   end

   // Completed packet is applied one cycle after its last byte is latched
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_timer    <= '0;
         r_apply    <= 1'b0;
         r_valid    <= 1'b0;
         r_sync_err <= 1'b0;
         r_btn      <= '0;
         r_b0_btn   <= '0;
         r_x_sign   <= 1'b0;
         r_y_sign   <= 1'b0;
         r_x_ovf    <= 1'b0;
         r_y_ovf    <= 1'b0;
         r_dx       <= '0;
         r_dy       <= '0;
      end else begin
         r_apply    <= w_complete;
         r_valid    <= r_apply;
         r_sync_err <= w_drop | w_abort;
         if (w_tmr_clr) begin
            r_timer <= '0;
         end else if (w_tmr_inc) begin
            r_timer <= r_timer + 1'b1;
         end
         if (w_lat_b0) begin
            r_b0_btn <= rx_data[B0_BTN_M:B0_BTN_L];
            r_x_sign <= rx_data[B0_X_SIGN];
            r_y_sign <= rx_data[B0_Y_SIGN];
            r_x_ovf  <= rx_data[B0_X_OVF];
            r_y_ovf  <= rx_data[B0_Y_OVF];
         end
         if (w_lat_dx) begin
            r_dx <= rx_data;
         end
         if (w_lat_dy) begin
            r_dy <= rx_data;
         end
         if (r_apply) begin
            r_btn <= w_btn_next;
         end
      end
   end

   mouse_axis_accum #(
      .MAX    (H_RES - 1),
      .INVERT (1'b0)
   ) u_x_accum (
      .clk      (clk),
      .rst_n    (rst_n),
      .delta    ({r_x_sign, r_dx}),
      .overflow (r_x_ovf),
      .apply    (r_apply),
      .coord    (x_o)
   );

   // Mouse "up" is positive dy, screen y grows downward
   mouse_axis_accum #(
      .MAX    (V_RES - 1),
      .INVERT (1'b1)
   ) u_y_accum (
      .clk      (clk),
      .rst_n    (rst_n),
      .delta    ({r_y_sign, r_dy}),
      .overflow (r_y_ovf),
      .apply    (r_apply),
      .coord    (y_o)
   );

   assign btn_o      = r_btn;
   assign valid_o    = r_valid;
   assign sync_err_o = r_sync_err;

endmodule
`default_nettype wire

// File: tb/tb_mouse_packet_decoder.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_mouse_packet_decoder                                                    |
// | Directed self-checking bench for mouse_packet_decoder (short TIMEOUT).     |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_mouse_packet_decoder;

   localparam int c_timeout = 40;
`ifdef MOUSE_WHEEL_EN
   localparam logic [7:0] c_wheel_btn = 8'hF0;
`else
   localparam logic [7:0] c_wheel_btn = 8'h00;
`endif

   logic        clk;
   logic        rst_n;
   logic [7:0]  rx_data;
   logic        rx_valid;
   logic [11:0] x_o;
   logic [11:0] y_o;
   logic [7:0]  btn_o;
   logic        valid_o;
   logic        sync_err_o;

   int n_total = 0;
   int n_bad   = 0;
   int n_valid = 0;

   mouse_packet_decoder #(
      .H_RES   (640),
      .V_RES   (480),
      .TIMEOUT (c_timeout)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .rx_data    (rx_data),
      .rx_valid   (rx_valid),
      .x_o        (x_o),
      .y_o        (y_o),
      .btn_o      (btn_o),
      .valid_o    (valid_o),
      .sync_err_o (sync_err_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (valid_o) n_valid++;
   end

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d (0x%0h) want %0d (0x%0h)", tag, act, act, exp, exp);
      end
   endtask

   // Called at a negedge; byte is sampled at the following posedge
   task automatic put(input logic [7:0] b);
      rx_data  = b;
      rx_valid = 1'b1;
      @(negedge clk);
      rx_valid = 1'b0;
   endtask

   task automatic send_pkt(input logic [7:0] b0, input logic [7:0] b1,
                           input logic [7:0] b2, input logic [7:0] b3);
      put(b0);
      put(b1);
      put(b2);
`ifdef MOUSE_WHEEL_EN
      put(b3);
`else
      if (b3 === 8'hxx) rx_data = 8'h00;
`endif
   endtask

   task automatic expect_pkt(input string tag, input int ex, input int ey, input int eb);
      chk({tag, "_early"}, 32'(valid_o), 0);
      @(negedge clk);
      chk({tag, "_valid"}, 32'(valid_o), 1);
      chk({tag, "_x"}, 32'(x_o), ex);
      chk({tag, "_y"}, 32'(y_o), ey);
      chk({tag, "_btn"}, 32'(btn_o), eb);
      @(negedge clk);
      chk({tag, "_vlow"}, 32'(valid_o), 0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int v0;
      int hit_at;
      rst_n    = 1'b0;
      rx_data  = 8'h00;
      rx_valid = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst_x", 32'(x_o), 320);
      chk("rst_y", 32'(y_o), 240);
      chk("rst_btn", 32'(btn_o), 0);
      chk("rst_valid", 32'(valid_o), 0);
      chk("rst_serr", 32'(sync_err_o), 0);
      rst_n = 1'b1;

      send_pkt(8'h09, 8'h0A, 8'h05, 8'h00);
      expect_pkt("basic", 330, 235, 8'h01 | 0);

      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      chk("rst2_x", 32'(x_o), 320);

      send_pkt(8'h18, 8'hF6, 8'h00, 8'h00);
      expect_pkt("neg10", 310, 240, 0);
      send_pkt(8'h18, 8'h9C, 8'h00, 8'h00);
      send_pkt(8'h18, 8'h9C, 8'h00, 8'h00);
      send_pkt(8'h18, 8'h9C, 8'h00, 8'h00);
      expect_pkt("neg100_3", 10, 240, 0);
      send_pkt(8'h18, 8'h9C, 8'h00, 8'h00);
      expect_pkt("xsat_lo", 0, 240, 0);
      send_pkt(8'h18, 8'h9C, 8'h00, 8'h00);
      expect_pkt("xsat_lo2", 0, 240, 0);

      send_pkt(8'h08, 8'hFF, 8'h00, 8'h00);
      send_pkt(8'h08, 8'hFF, 8'h00, 8'h00);
      expect_pkt("xplus", 510, 240, 0);
      send_pkt(8'h08, 8'hFF, 8'h00, 8'h00);
      expect_pkt("xsat_hi", 639, 240, 0);

      send_pkt(8'h28, 8'h00, 8'h01, 8'h00);
      expect_pkt("ysat_hi", 639, 479, 0);
      send_pkt(8'h08, 8'h00, 8'hFF, 8'h00);
      expect_pkt("yup", 639, 224, 0);
      send_pkt(8'h08, 8'h00, 8'hFF, 8'h00);
      expect_pkt("ysat_lo", 639, 0, 0);

      put(8'h02);
      chk("drop_serr", 32'(sync_err_o), 1);
      chk("drop_valid", 32'(valid_o), 0);
      @(negedge clk);
      chk("drop_serr_low", 32'(sync_err_o), 0);
      send_pkt(8'h08, 8'h00, 8'h00, 8'h00);
      expect_pkt("after_drop", 639, 0, 0);

      put(8'h09);
      put(8'h0A);
      v0     = n_valid;
      hit_at = -1;
      for (int i = 1; i <= c_timeout + 5; i++) begin
         @(negedge clk);
         if (sync_err_o && hit_at < 0) hit_at = i;
      end
      #1;
      chk("tmo_seen", 32'(hit_at >= c_timeout && hit_at <= c_timeout + 1), 1);
      chk("tmo_novalid", 32'(n_valid - v0), 0);
      chk("tmo_x", 32'(x_o), 639);
      send_pkt(8'h39, 8'hF6, 8'hF6, 8'h00);
      expect_pkt("after_tmo", 629, 10, 1);

      send_pkt(8'h48, 8'h7F, 8'h03, 8'h00);
      expect_pkt("xovf", 629, 7, 0);
      send_pkt(8'h88, 8'h05, 8'h7F, 8'h00);
      expect_pkt("yovf", 634, 7, 0);

      v0 = n_valid;
      send_pkt(8'h0A, 8'h01, 8'h00, 8'h00);
      send_pkt(8'h0C, 8'h02, 8'h00, 8'h00);
      @(negedge clk);
      chk("b2b_valid", 32'(valid_o), 1);
      chk("b2b_x", 32'(x_o), 637);
      chk("b2b_btn", 32'(btn_o), 8'h04);
      @(negedge clk);
      #1;
      chk("b2b_count", 32'(n_valid - v0), 2);

      send_pkt(8'h08, 8'h00, 8'h00, 8'h0F);
      expect_pkt("wheel", 637, 7, c_wheel_btn);

      put(8'h09);
      put(8'h10);
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      chk("midrst_x", 32'(x_o), 320);
      chk("midrst_y", 32'(y_o), 240);
      chk("midrst_valid", 32'(valid_o), 0);
      send_pkt(8'h09, 8'h0A, 8'h05, 8'h00);
      expect_pkt("after_midrst", 330, 235, 1);

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
`default_nettype wire
